// File: rtl/kfpga_config_loader.sv
// kfpga_config_loader: assembles a valid/ready bitstream into the fabric config vector,
// verifies a trailing XOR checksum and only then releases the core from reset.
module kfpga_config_loader #(
  parameter int CONFIG_WIDTH = 42368,
  parameter int WORD_WIDTH   = 32
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    load_start,
  input  logic [WORD_WIDTH-1:0]   data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    core_nreset,
  output logic                    load_done,
  output logic                    load_error
);

  localparam int NWORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int CNT_W  = $clog2(NWORDS + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [CNT_W-1:0]        r_cnt;
  logic [WORD_WIDTH-1:0]   r_acc;
  logic [CONFIG_WIDTH-1:0] r_config;
  logic [CONFIG_WIDTH-1:0] w_config_next;
  logic                    w_ready;
  logic                    w_xfer;
  logic                    w_last_word;
  logic                    w_sum_ok;

  // Ready only while words are expected; never depends on data_valid.
  assign w_ready     = (r_state == ST_LOAD) || (r_state == ST_CHECK);
  assign w_xfer      = data_valid && w_ready;
  assign w_last_word = (r_cnt == CNT_W'(NWORDS - 1));
  assign w_sum_ok    = (data_in == r_acc);

  // Outputs decoded from state: the core only leaves reset once the checksum matched.
  assign data_ready  = w_ready;
  assign core_nreset = (r_state == ST_DONE);
  assign load_done   = (r_state == ST_DONE);
  assign load_error  = (r_state == ST_ERROR);
  assign config_out  = r_config;

  // State register.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; load_start overrides everything, including a coincident transfer.
  always_comb begin
    w_state_next = r_state;
    if (load_start) begin
      w_state_next = ST_LOAD;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_next = ST_IDLE;
        ST_LOAD:  begin
          if (w_xfer && w_last_word) begin
            w_state_next = ST_CHECK;
          end else begin
            w_state_next = ST_LOAD;
          end
        end
        ST_CHECK: begin
          if (w_xfer) begin
            w_state_next = w_sum_ok ? ST_DONE : ST_ERROR;
          end else begin
            w_state_next = ST_CHECK;
          end
        end
        ST_DONE:  w_state_next = ST_DONE;
        ST_ERROR: w_state_next = ST_ERROR;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  // Place the incoming word into its slot; bits past CONFIG_WIDTH-1 simply have no home.
  always_comb begin
    w_config_next = r_config;
    for (int b = 0; b < CONFIG_WIDTH; b++) begin
      if (r_cnt == CNT_W'(b / WORD_WIDTH)) begin
        w_config_next[b] = data_in[b % WORD_WIDTH];
      end else begin
        w_config_next[b] = r_config[b];
      end
    end
  end

  // Datapath: word counter, checksum accumulator and config vector.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_config <= '0;
    end else if (load_start) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_config <= '0;
    end else if ((r_state == ST_LOAD) && w_xfer) begin
      r_cnt    <= r_cnt + CNT_W'(1);
      r_acc    <= r_acc ^ data_in;
      r_config <= w_config_next;
    end else if ((r_state == ST_CHECK) && w_xfer && !w_sum_ok) begin
      r_config <= '0;
    end else begin
      r_cnt    <= r_cnt;
      r_acc    <= r_acc;
      r_config <= r_config;
    end
  end

endmodule

// File: tb/tb_kfpga_config_loader.sv
// Directed bench for kfpga_config_loader with CONFIG_WIDTH=40, WORD_WIDTH=16 (NWORDS=3).
module tb_kfpga_config_loader;

  localparam int CW = 40;
  localparam int WW = 16;

  logic          clock;
  logic          nreset;
  logic          load_start;
  logic [WW-1:0] data_in;
  logic          data_valid;
  logic          data_ready;
  logic [CW-1:0] config_out;
  logic          core_nreset;
  logic          load_done;
  logic          load_error;

  int vectors;
  int miscompares;

  kfpga_config_loader #(
    .CONFIG_WIDTH(CW),
    .WORD_WIDTH  (WW)
  ) dut (
    .clock      (clock),
    .nreset     (nreset),
    .load_start (load_start),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .config_out (config_out),
    .core_nreset(core_nreset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_word(input logic [WW-1:0] w);
    data_in    = w;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic check_done(input string tag, input logic [CW-1:0] exp_cfg);
    check({tag, "_done"},   64'(load_done),   64'd1);
    check({tag, "_corenr"}, 64'(core_nreset), 64'd1);
    check({tag, "_err"},    64'(load_error),  64'd0);
    check({tag, "_ready"},  64'(data_ready),  64'd0);
    check({tag, "_cfg"},    64'(config_out),  64'(exp_cfg));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_cfg"},    64'(config_out),  64'd0);
    check({tag, "_done"},   64'(load_done),   64'd0);
    check({tag, "_corenr"}, 64'(core_nreset), 64'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    nreset      = 1'b0;
    load_start  = 1'b0;
    data_in     = 16'h0000;
    data_valid  = 1'b0;
    #12;
    // Reset values
    check("rst_cfg",    64'(config_out),  64'd0);
    check("rst_ready",  64'(data_ready),  64'd0);
    check("rst_corenr", 64'(core_nreset), 64'd0);
    check("rst_done",   64'(load_done),   64'd0);
    check("rst_err",    64'(load_error),  64'd0);
    nreset = 1'b1;
    tick();

    // IDLE ignores words
    data_in = 16'hBEEF; data_valid = 1'b1;
    tick(); tick();
    data_valid = 1'b0;
    check("idle_ready", 64'(data_ready), 64'd0);
    check("idle_cfg",   64'(config_out), 64'd0);

    // 1: good load
    pulse_start();
    check("t1_ready_load", 64'(data_ready), 64'd1);
    check_cleared("t1_start");
    send_word(16'h1234);
    send_word(16'h5678);
    send_word(16'hAB9A);
    check("t1_ready_check", 64'(data_ready), 64'd1);
    check("t1_done_early",  64'(load_done),  64'd0);
    check("t1_corenr_early", 64'(core_nreset), 64'd0);
    send_word(16'hEFD6);
    check_done("t1", 40'h9A_5678_1234);
    tick();
    check("t1_cfg_hold", 64'(config_out), 64'h9A_5678_1234);

    // 2: bad checksum
    pulse_start();
    send_word(16'h1234);
    send_word(16'h5678);
    send_word(16'hAB9A);
    send_word(16'hEFD7);
    check("t2_err",    64'(load_error),  64'd1);
    check("t2_ready",  64'(data_ready),  64'd0);
    check_cleared("t2");
    send_word(16'hEFD6);
    send_word(16'h1234);
    check("t2_err_stay", 64'(load_error), 64'd1);
    check_cleared("t2_after");

    // 3: good load with random valid gaps
    pulse_start();
    begin
      logic [WW-1:0] words [4];
      words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'hAB9A; words[3] = 16'hEFD6;
      for (int i = 0; i < 4; i++) begin
        int gap;
        gap = int'($urandom_range(3));
        data_in = words[i];
        for (int g = 0; g < gap; g++) begin
          tick();
          check("t3_gap_ready", 64'(data_ready), 64'd1);
          check("t3_gap_done",  64'(load_done),  64'd0);
        end
        send_word(words[i]);
      end
    end
    check_done("t3", 40'h9A_5678_1234);

    // 4: restart mid-load, coincident word dropped
    pulse_start();
    send_word(16'h1111);
    send_word(16'h2222);
    data_in = 16'hDEAD; data_valid = 1'b1; load_start = 1'b1;
    tick();
    data_valid = 1'b0; load_start = 1'b0;
    check("t4_ready", 64'(data_ready), 64'd1);
    check_cleared("t4_restart");
    send_word(16'h1234);
    send_word(16'h5678);
    send_word(16'hAB9A);
    send_word(16'hEFD6);
    check_done("t4", 40'h9A_5678_1234);

    // 5: asynchronous reset mid-load
    pulse_start();
    send_word(16'h1234);
    send_word(16'h5678);
    #2 nreset = 1'b0;
    #1;
    check("t5_rst_ready", 64'(data_ready), 64'd0);
    check("t5_rst_err",   64'(load_error), 64'd0);
    check_cleared("t5_rst");
    tick();
    nreset = 1'b1;
    tick();
    check("t5_idle_ready", 64'(data_ready), 64'd0);
    check("t5_idle_cfg",   64'(config_out), 64'd0);
    pulse_start();
    send_word(16'h1234);
    send_word(16'h5678);
    send_word(16'hAB9A);
    send_word(16'hEFD6);
    check_done("t5", 40'h9A_5678_1234);

    // 6: reload from DONE
    pulse_start();
    check("t6_ready", 64'(data_ready), 64'd1);
    check_cleared("t6_start");
    send_word(16'hFFFF);
    send_word(16'hFFFF);
    send_word(16'hFFFF);
    send_word(16'hFFFF);
    check_done("t6", 40'hFF_FFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
